sram_ctrl_arb: RTL and testbench
================================

// Module: sram_ctrl_arb
// PURPOSE
//   Synchronous controller and two-port arbiter for the external async 32Kx8 SRAM.
//   Serves 16-bit word accesses from the CPU (read/write, byte enables) and the video refresh engine (read-only).
//   Sequences each word as two byte cycles, big-endian: even (high) byte first, then odd (low) byte.
//   Drives the SRAM strobes directly. The dq tri-state buffer lives at the top level, controlled by sram_dq_oe.
// PARAMETERS
//   WAIT_CYC  1  cycles the oe_n/we_n strobe is held low per byte (>=1)
//   VID_MAX   4  consecutive video grants allowed while CPU is pending before the CPU is forced in (>=1)
// PORTS
//   clk          in   1   system clock
//   rst_n        in   1   synchronous active-low reset
//   cpu_req      in   1   CPU request; held high until cpu_ack
//   cpu_we       in   1   1=write, 0=read; stable while cpu_req high
//   cpu_be       in   2   byte enables: [1]=high/even byte, [0]=low/odd byte
//   cpu_addr     in   14  word address
//   cpu_wdata    in   16  write data, [15:8] to even byte
//   cpu_ack      out  1   one-cycle completion pulse
//   cpu_rdata    out  16  read data, valid while cpu_ack high
//   vid_req      in   1   video read request; held high until vid_ack
//   vid_addr     in   14  word address
//   vid_ack      out  1   one-cycle completion pulse
//   vid_rdata    out  16  read data, valid while vid_ack high
//   sram_ce_n    out  1   SRAM chip enable, active low
//   sram_oe_n    out  1   SRAM output enable, active low
//   sram_we_n    out  1   SRAM write enable, active low
//   sram_addr    out  15  byte address = {word_addr, lane}; lane 0 = even/high byte
//   sram_dq_o    out  8   write data to pad
//   sram_dq_oe   out  1   1 = drive pad with sram_dq_o
//   sram_dq_i    in   8   read data from pad
// BEHAVIOUR
//   Reset (rst_n low at an edge): state IDLE.
//     ce_n=oe_n=we_n=1, dq_oe=0, addr=0, dq_o=0, acks=0, rdata=0, vid-grant count=0.
//   Reset mid-transaction aborts it: strobes go high at the next edge, no ack is issued.
//   All SRAM outputs are registered. ce_n is low only in SETUP/STROBE/HOLD.
//   FSM: IDLE -> SETUP -> STROBE(xWAIT_CYC) -> HOLD -> [SETUP (2nd byte) | IDLE].
//     SETUP: addr valid, ce_n=0, strobes high; on a write, dq_oe=1 and dq_o=byte.
//     STROBE: oe_n=0 (read) or we_n=0 (write); a counter counts WAIT_CYC cycles.
//       Reads sample sram_dq_i at the last STROBE edge.
//     HOLD: strobes high; addr and dq_o held stable.
//       dq_oe stays 1 through HOLD on writes and drops at the next edge.
//   Arbitration happens only in IDLE; a transaction in progress is never preempted.
//     Video wins over CPU, except when the CPU is pending and the vid-grant count == VID_MAX;
//     then the CPU wins.
//     vid-grant count: +1 per video grant while cpu_req is high; cleared on any CPU grant
//       or when cpu_req is low; saturates at VID_MAX.
//   Byte lanes: the CPU skips lanes whose be bit is 0; video always does both lanes.
//     Disabled read lanes return 8'h00 in cpu_rdata.
//     cpu_be=00: no SRAM cycle; cpu_ack is asserted the cycle after the grant.
//   Latency (grant edge -> ack): the ack asserts during the final HOLD cycle.
//     Word access: 2*(WAIT_CYC+2) cycles (6 at WAIT_CYC=1).
//     Single lane: WAIT_CYC+2 cycles.
//   Ack/rdata: registered, one-cycle pulse; rdata holds its value until the next ack on that port.
//     FSM returns to IDLE on the edge after the ack.
//     A requester must drop req on the edge after the ack; a req seen high in IDLE is a new request.
//   Simultaneous cpu_req and vid_req in IDLE: resolved per the priority rule above.
//     The loser waits; its req stays asserted.
// TESTING
//   1. Reset, then CPU write addr 0x0012 data 0xBEEF be=11 (WAIT_CYC=1) -> byte 0x0024=0xBE, byte 0x0025=0xEF.
//      cpu_ack 6 cycles after the grant; we_n low exactly 1 cycle per byte.
//   2. CPU read of 0x0012 be=10 -> one byte cycle, cpu_rdata=0xBE00, ack after 3 cycles; oe_n never low on lane 1.
//   3. cpu_req and vid_req both held continuously (VID_MAX=4) -> grants V,V,V,V,C,V,V,V,V,C.
//      No back-to-back strobe overlap.
//   4. CPU request with be=00 -> ack 1 cycle after the grant; ce_n stays high throughout.
//   5. rst_n low during the STROBE cycle of a write -> next edge has we_n=ce_n=1, dq_oe=0, and no ack.
//      A new request after reset completes normally.
//   6. WAIT_CYC=3, video read of word 0x3FFF -> addr 0x7FFE then 0x7FFF; oe_n low 3 cycles each.
//      vid_ack at cycle 10; data is correct.

Source files
------------

// File: rtl/sram_ctrl_arb.sv
// rtl/sram_ctrl_arb.sv - controller and CPU/video arbiter for an async 32Kx8 SRAM
//
// Each 16-bit word access is split into two byte cycles, big-endian. The even
// (high) byte is lane 0 and goes first. Each byte runs SETUP -> STROBE x WAIT_CYC -> HOLD.
// Video normally wins arbitration. The exception is when the CPU is pending and
// has already been passed over VID_MAX times; then the CPU is served.
//
// Ports:
//   clk, rst_n                      clock, synchronous active-low reset
//   cpu_req/we/be/addr/wdata        CPU word request (read/write, byte enables)
//   cpu_ack, cpu_rdata              CPU completion pulse and read data
//   vid_req/addr                    video word read request
//   vid_ack, vid_rdata              video completion pulse and read data
//   sram_ce_n/oe_n/we_n             SRAM strobes, active low, registered
//   sram_addr                       byte address {word_addr, lane}
//   sram_dq_o, sram_dq_oe           write data and pad drive enable
//   sram_dq_i                       read data from pad
module sram_ctrl_arb #(
    parameter int WAIT_CYC = 1,
    parameter int VID_MAX  = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cpu_req,
    input  logic        cpu_we,
    input  logic [1:0]  cpu_be,
    input  logic [13:0] cpu_addr,
    input  logic [15:0] cpu_wdata,
    output logic        cpu_ack,
    output logic [15:0] cpu_rdata,
    input  logic        vid_req,
    input  logic [13:0] vid_addr,
    output logic        vid_ack,
    output logic [15:0] vid_rdata,
    output logic        sram_ce_n,
    output logic        sram_oe_n,
    output logic        sram_we_n,
    output logic [14:0] sram_addr,
    output logic [7:0]  sram_dq_o,
    output logic        sram_dq_oe,
    input  logic [7:0]  sram_dq_i
);

    localparam int WCW = (WAIT_CYC > 1) ? $clog2(WAIT_CYC) : 1;
    localparam int VCW = $clog2(VID_MAX + 1);
    localparam logic [WCW-1:0] WAIT_LAST = WCW'(WAIT_CYC - 1);
    localparam logic [VCW-1:0] VID_FULL  = VCW'(VID_MAX);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_STROBE,
        S_HOLD,
        S_DONE
    } state_t;

    state_t          state;
    logic [WCW-1:0]  wcnt;
    logic [VCW-1:0]  vid_cnt;
    logic            lane;
    logic            own_cpu;
    logic            cur_we;
    logic [1:0]      cur_be;
    logic [13:0]     cur_addr;
    logic [15:0]     cur_wdata;
    logic [7:0]      hi_byte;

    logic            grant_cpu;
    logic            last_lane;
    logic [15:0]     rd_word;

    // CPU wins only when video is idle or the CPU has been starved VID_MAX times.
    assign grant_cpu = cpu_req && (!vid_req || vid_cnt == VID_FULL);
    // Lane 1 is always the last lane. Lane 0 is also the last when the low byte is disabled.
    assign last_lane = lane | ~cur_be[0];
    // Assemble the word at the final strobe edge. A disabled lane reads as zero.
    assign rd_word   = lane ? {(cur_be[1] ? hi_byte : 8'h00), sram_dq_i}
                            : {sram_dq_i, 8'h00};

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            wcnt       <= '0;
            vid_cnt    <= '0;
            lane       <= 1'b0;
            own_cpu    <= 1'b0;
            cur_we     <= 1'b0;
            cur_be     <= 2'b00;
            cur_addr   <= '0;
            cur_wdata  <= '0;
            hi_byte    <= '0;
            cpu_ack    <= 1'b0;
            cpu_rdata  <= '0;
            vid_ack    <= 1'b0;
            vid_rdata  <= '0;
            sram_ce_n  <= 1'b1;
            sram_oe_n  <= 1'b1;
            sram_we_n  <= 1'b1;
            sram_addr  <= '0;
            sram_dq_o  <= '0;
            sram_dq_oe <= 1'b0;
        end else begin
            cpu_ack <= 1'b0;
            vid_ack <= 1'b0;
            if (!cpu_req) begin
                vid_cnt <= '0;
            end
            case (state)
                S_IDLE: begin
                    if (grant_cpu) begin
                        vid_cnt   <= '0;
                        own_cpu   <= 1'b1;
                        cur_we    <= cpu_we;
                        cur_be    <= cpu_be;
                        cur_addr  <= cpu_addr;
                        cur_wdata <= cpu_wdata;
                        if (cpu_be == 2'b00) begin
                            // Nothing to transfer: acknowledge without touching the SRAM.
                            cpu_ack <= 1'b1;
                            if (!cpu_we) begin
                                cpu_rdata <= '0;
                            end
                            state <= S_DONE;
                        end else begin
                            lane       <= ~cpu_be[1];
                            sram_addr  <= {cpu_addr, ~cpu_be[1]};
                            sram_ce_n  <= 1'b0;
                            sram_dq_oe <= cpu_we;
                            sram_dq_o  <= cpu_we ? (cpu_be[1] ? cpu_wdata[15:8] : cpu_wdata[7:0])
                                                 : 8'h00;
                            state      <= S_SETUP;
                        end
                    end else if (vid_req) begin
                        // A video grant with the CPU waiting implies vid_cnt < VID_MAX,
                        // so the increment saturates at VID_MAX by construction.
                        if (cpu_req) begin
                            vid_cnt <= vid_cnt + 1'b1;
                        end
                        own_cpu    <= 1'b0;
                        cur_we     <= 1'b0;
                        cur_be     <= 2'b11;
                        cur_addr   <= vid_addr;
                        lane       <= 1'b0;
                        sram_addr  <= {vid_addr, 1'b0};
                        sram_ce_n  <= 1'b0;
                        sram_dq_oe <= 1'b0;
                        state      <= S_SETUP;
                    end
                end
                S_SETUP: begin
                    sram_oe_n <= cur_we;
                    sram_we_n <= ~cur_we;
                    wcnt      <= '0;
                    state     <= S_STROBE;
                end
                S_STROBE: begin
                    if (wcnt == WAIT_LAST) begin
                        sram_oe_n <= 1'b1;
                        sram_we_n <= 1'b1;
                        state     <= S_HOLD;
                        if (!cur_we && !lane) begin
                            hi_byte <= sram_dq_i;
                        end
                        // Ack is registered here so that it is high during the final HOLD.
                        if (last_lane) begin
                            if (own_cpu) begin
                                cpu_ack <= 1'b1;
                                if (!cur_we) begin
                                    cpu_rdata <= rd_word;
                                end
                            end else begin
                                vid_ack   <= 1'b1;
                                vid_rdata <= rd_word;
                            end
                        end
                    end else begin
                        wcnt <= wcnt + 1'b1;
                    end
                end
                S_HOLD: begin
                    if (last_lane) begin
                        sram_ce_n  <= 1'b1;
                        sram_dq_oe <= 1'b0;
                        state      <= S_IDLE;
                    end else begin
                        lane       <= 1'b1;
                        sram_addr  <= {cur_addr, 1'b1};
                        sram_dq_o  <= cur_we ? cur_wdata[7:0] : 8'h00;
                        sram_dq_oe <= cur_we;
                        state      <= S_SETUP;
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sram_ctrl_arb.sv
// tb/tb_sram_ctrl_arb.sv - directed bench for sram_ctrl_arb
module tb_sram_ctrl_arb;

    logic        clk = 1'b0;
    logic        rst_n;

    logic        cpu_req, cpu_we;
    logic [1:0]  cpu_be;
    logic [13:0] cpu_addr;
    logic [15:0] cpu_wdata;
    logic        cpu_ack;
    logic [15:0] cpu_rdata;
    logic        vid_req;
    logic [13:0] vid_addr;
    logic        vid_ack;
    logic [15:0] vid_rdata;
    logic        ce_n, oe_n, we_n, dq_oe;
    logic [14:0] sram_addr;
    logic [7:0]  dq_o, dq_i;

    logic        cpu_req3, cpu_we3;
    logic [1:0]  cpu_be3;
    logic [13:0] cpu_addr3;
    logic [15:0] cpu_wdata3;
    logic        cpu_ack3;
    logic [15:0] cpu_rdata3;
    logic        vid_req3;
    logic [13:0] vid_addr3;
    logic        vid_ack3;
    logic [15:0] vid_rdata3;
    logic        ce_n3, oe_n3, we_n3, dq_oe3;
    logic [14:0] sram_addr3;
    logic [7:0]  dq_o3, dq_i3;

    logic [7:0]  mem [0:32767];

    int n_checks = 0;
    int n_fail   = 0;
    int we_low = 0, we_fall = 0, oe_low = 0, oe_lane1 = 0, ce_low = 0, viol = 0;
    int oe3_fe = 0, oe3_ff = 0;
    logic        we_prev = 1'b1;
    logic        strb_prev = 1'b0;
    logic [14:0] addr_prev = '0;
    logic        seen3 = 1'b0;
    logic [14:0] first3 = '0;

    sram_ctrl_arb #(.WAIT_CYC(1), .VID_MAX(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_be(cpu_be), .cpu_addr(cpu_addr),
        .cpu_wdata(cpu_wdata), .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
        .vid_req(vid_req), .vid_addr(vid_addr), .vid_ack(vid_ack), .vid_rdata(vid_rdata),
        .sram_ce_n(ce_n), .sram_oe_n(oe_n), .sram_we_n(we_n), .sram_addr(sram_addr),
        .sram_dq_o(dq_o), .sram_dq_oe(dq_oe), .sram_dq_i(dq_i)
    );

    sram_ctrl_arb #(.WAIT_CYC(3), .VID_MAX(4)) dut3 (
        .clk(clk), .rst_n(rst_n),
        .cpu_req(cpu_req3), .cpu_we(cpu_we3), .cpu_be(cpu_be3), .cpu_addr(cpu_addr3),
        .cpu_wdata(cpu_wdata3), .cpu_ack(cpu_ack3), .cpu_rdata(cpu_rdata3),
        .vid_req(vid_req3), .vid_addr(vid_addr3), .vid_ack(vid_ack3), .vid_rdata(vid_rdata3),
        .sram_ce_n(ce_n3), .sram_oe_n(oe_n3), .sram_we_n(we_n3), .sram_addr(sram_addr3),
        .sram_dq_o(dq_o3), .sram_dq_oe(dq_oe3), .sram_dq_i(dq_i3)
    );

    initial forever #5 clk = ~clk;

    assign dq_i  = (!ce_n && !oe_n) ? mem[sram_addr] : 8'hA5;
    assign dq_i3 = (!ce_n3 && !oe_n3) ? (sram_addr3[0] ? 8'h5A : 8'hC3) : 8'hEE;

    // SRAM model and strobe monitors, sampled mid-cycle.
    always @(negedge clk) begin
        if (!ce_n && !we_n && dq_oe) mem[sram_addr] <= dq_o;
        if (!we_n) we_low++;
        if (!we_n && we_prev) we_fall++;
        we_prev = we_n;
        if (!oe_n) oe_low++;
        if (!oe_n && sram_addr[0]) oe_lane1++;
        if (!ce_n) ce_low++;
        if (!oe_n && !we_n) viol++;
        if ((!oe_n || !we_n) && ce_n) viol++;
        if ((!oe_n || !we_n) && strb_prev && sram_addr != addr_prev) viol++;
        strb_prev = !oe_n || !we_n;
        addr_prev = sram_addr;
        if (!oe_n3) begin
            if (sram_addr3 == 15'h7FFE) oe3_fe++;
            else if (sram_addr3 == 15'h7FFF) oe3_ff++;
            if (!seen3) begin
                first3 = sram_addr3;
                seen3  = 1'b1;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Issue one CPU access at a negedge while the controller is idle; latency is
    // the number of cycles after the grant edge in which cpu_ack is first seen.
    task automatic cpu_access(input logic we, input logic [1:0] be, input logic [13:0] addr,
                              input logic [15:0] wd, output int lat, output logic [15:0] rd);
        lat = 0;
        rd  = '0;
        cpu_we = we; cpu_be = be; cpu_addr = addr; cpu_wdata = wd; cpu_req = 1'b1;
        for (int k = 1; k <= 50; k++) begin
            @(negedge clk);
            if (cpu_ack) begin
                lat = k;
                rd  = cpu_rdata;
                break;
            end
        end
        cpu_req = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    int          lat, s0, s1, nacks;
    logic [15:0] rd, c_rd;
    logic [9:0]  seq;

    initial begin
        rst_n = 1'b0;
        cpu_req = 0; cpu_we = 0; cpu_be = 0; cpu_addr = 0; cpu_wdata = 0;
        vid_req = 0; vid_addr = 0;
        cpu_req3 = 0; cpu_we3 = 0; cpu_be3 = 0; cpu_addr3 = 0; cpu_wdata3 = 0;
        vid_req3 = 0; vid_addr3 = 0;
        repeat (3) @(negedge clk);

        check("rst_strobes", 32'({ce_n, oe_n, we_n, dq_oe}), 32'hE);
        check("rst_addr", 32'(sram_addr), 32'h0);
        check("rst_dq_o", 32'(dq_o), 32'h0);
        check("rst_acks", 32'({cpu_ack, vid_ack}), 32'h0);
        check("rst_rdata", 32'({cpu_rdata, vid_rdata}), 32'h0);
        check("rst_strobes3", 32'({ce_n3, oe_n3, we_n3, dq_oe3}), 32'hE);
        rst_n = 1'b1;
        @(negedge clk);

        // Word write, both lanes.
        s0 = we_low; s1 = we_fall;
        cpu_access(1'b1, 2'b11, 14'h0012, 16'hBEEF, lat, rd);
        check("t1_latency", 32'(lat), 32'd6);
        check("t1_byte24", 32'(mem[15'h0024]), 32'hBE);
        check("t1_byte25", 32'(mem[15'h0025]), 32'hEF);
        check("t1_we_cycles", 32'(we_low - s0), 32'd2);
        check("t1_we_pulses", 32'(we_fall - s1), 32'd2);

        // High-lane-only read.
        s0 = oe_low; s1 = oe_lane1;
        cpu_access(1'b0, 2'b10, 14'h0012, 16'h0000, lat, rd);
        check("t2_latency", 32'(lat), 32'd3);
        check("t2_rdata", 32'(rd), 32'hBE00);
        check("t2_oe_cycles", 32'(oe_low - s0), 32'd1);
        check("t2_oe_lane1", 32'(oe_lane1 - s1), 32'd0);

        // Both requesters held high: fairness pattern.
        seq = '0; nacks = 0; c_rd = '0;
        cpu_we = 1'b0; cpu_be = 2'b11; cpu_addr = 14'h0012; cpu_req = 1'b1;
        vid_addr = 14'h0040; vid_req = 1'b1;
        for (int k = 0; k < 300 && nacks < 10; k++) begin
            @(negedge clk);
            if (cpu_ack || vid_ack) begin
                if (cpu_ack && nacks < 5) c_rd = cpu_rdata;
                seq = {seq[8:0], cpu_ack};
                nacks++;
            end
        end
        cpu_req = 1'b0; vid_req = 1'b0;
        repeat (3) @(negedge clk);
        check("t3_ack_count", 32'(nacks), 32'd10);
        check("t3_grant_order", 32'(seq), 32'h021);
        check("t3_cpu_rdata", 32'(c_rd), 32'hBEEF);
        check("t3_strobe_viol", 32'(viol), 32'd0);

        // Empty byte enable.
        s0 = ce_low;
        cpu_access(1'b1, 2'b00, 14'h0033, 16'hFFFF, lat, rd);
        check("t4_latency", 32'(lat), 32'd1);
        check("t4_ce_cycles", 32'(ce_low - s0), 32'd0);

        // Reset during the write strobe.
        cpu_we = 1'b1; cpu_be = 2'b11; cpu_addr = 14'h0100; cpu_wdata = 16'h1234; cpu_req = 1'b1;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (!we_n) break;
        end
        check("t5_in_strobe", 32'(we_n), 32'h0);
        rst_n = 1'b0; cpu_req = 1'b0;
        @(negedge clk);
        check("t5_abort_strobes", 32'({we_n, ce_n, dq_oe}), 32'h6);
        check("t5_abort_ack", 32'(cpu_ack), 32'h0);
        rst_n = 1'b1;
        @(negedge clk);
        check("t5_post_ack", 32'(cpu_ack), 32'h0);
        cpu_access(1'b0, 2'b01, 14'h0012, 16'h0000, lat, rd);
        check("t5_new_latency", 32'(lat), 32'd3);
        check("t5_new_rdata", 32'(rd), 32'h00EF);

        // WAIT_CYC=3 video read at the top word.
        lat = 0;
        vid_addr3 = 14'h3FFF; vid_req3 = 1'b1;
        for (int k = 1; k <= 50; k++) begin
            @(negedge clk);
            if (vid_ack3) begin
                lat = k;
                rd  = vid_rdata3;
                break;
            end
        end
        vid_req3 = 1'b0;
        repeat (2) @(negedge clk);
        check("t6_latency", 32'(lat), 32'd10);
        check("t6_rdata", 32'(rd), 32'hC35A);
        check("t6_first_addr", 32'(first3), 32'h7FFE);
        check("t6_oe_7ffe", 32'(oe3_fe), 32'd3);
        check("t6_oe_7fff", 32'(oe3_ff), 32'd3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
